// File: rtl/conv_window_feeder.sv
// Streams 3-row pixel columns from a synchronous-read image memory into a 3-slot window adder.
// Optional build macro FEEDER_STALL_EN adds a stall input that holds column fetches in RD0.
module conv_window_feeder #(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
`ifdef FEEDER_STALL_EN
   input  logic              stall,
`endif
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [DATA_W-1:0] din1,
   output logic [DATA_W-1:0] din2,
   output logic [DATA_W-1:0] din3,
   output logic [1:0]        addr,
   output logic              enable,
   output logic              endSign
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 2;
   localparam int RW = (HEIGHT > 3) ? $clog2(HEIGHT - 2) : 1;
   localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(WIDTH);

   if (WIDTH < 3 || HEIGHT < 3) begin : g_bad_dims
      $error("conv_window_feeder: WIDTH and HEIGHT must both be >= 3");
   end
   if (WIDTH * HEIGHT > 2 ** ADDR_W) begin : g_bad_addr
      $error("conv_window_feeder: WIDTH*HEIGHT does not fit in ADDR_W address bits");
   end

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD0  = 3'd1,
      S_RD1  = 3'd2,
      S_RD2  = 3'd3,
      S_LAST = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [RW-1:0]       row_r;
   logic [CW-1:0]       col_r;
   logic [1:0]          slot_r;
   logic [ADDR_W-1:0]   base_r;
   logic [ADDR_W-1:0]   rd_addr_r;
   logic                rd_en_r;
   logic [DATA_W-1:0]   h0_r;
   logic [DATA_W-1:0]   h1_r;
   logic [DATA_W-1:0]   din1_r;
   logic [DATA_W-1:0]   din2_r;
   logic [DATA_W-1:0]   din3_r;
   logic [1:0]          addr_r;
   logic                enable_r;
   logic                end_r;
   logic                busy_r;
   logic                done_r;
   logic                stall_s;
   logic                col_last_s;
   logic                row_last_s;

`ifdef FEEDER_STALL_EN
   assign stall_s = stall;
`else
   assign stall_s = 1'b0;
`endif

   assign col_last_s = (col_r == CW'(WIDTH - 1));
   assign row_last_s = (row_r == RW'(HEIGHT - 3));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic for the 4-cycle column fetch sequence.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_s = S_RD0;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_RD0: begin
            if (stall_s) begin
               state_s = S_RD0;
            end else begin
               state_s = S_RD1;
            end
         end
         S_RD1:  state_s = S_RD2;
         S_RD2:  state_s = S_LAST;
         S_LAST: begin
            if (col_last_s && row_last_s) begin
               state_s = S_DONE;
            end else begin
               state_s = S_RD0;
            end
         end
         S_DONE:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // Counters, read port, hold registers and the registered adder-side beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_r     <= '0;
         col_r     <= '0;
         slot_r    <= 2'd0;
         base_r    <= '0;
         rd_addr_r <= '0;
         rd_en_r   <= 1'b0;
         h0_r      <= '0;
         h1_r      <= '0;
         din1_r    <= '0;
         din2_r    <= '0;
         din3_r    <= '0;
         addr_r    <= 2'd0;
         enable_r  <= 1'b0;
         end_r     <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         rd_en_r  <= (state_s == S_RD0) || (state_s == S_RD1) || (state_s == S_RD2);
         done_r   <= (state_s == S_DONE);
         enable_r <= 1'b0;
         end_r    <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  busy_r    <= 1'b1;
                  row_r     <= '0;
                  col_r     <= '0;
                  slot_r    <= 2'd0;
                  base_r    <= '0;
                  rd_addr_r <= '0;
               end
            end
            S_RD0: begin
               if (!stall_s) begin
                  rd_addr_r <= rd_addr_r + W_STEP;
               end
            end
            S_RD1: begin
               h0_r      <= mem_rd_data;
               rd_addr_r <= rd_addr_r + W_STEP;
            end
            S_RD2: begin
               h1_r <= mem_rd_data;
            end
            S_LAST: begin
               din1_r   <= h0_r;
               din2_r   <= h1_r;
               din3_r   <= mem_rd_data;
               addr_r   <= slot_r;
               enable_r <= (col_r >= CW'(2));
               end_r    <= (col_r >= CW'(2)) && col_last_s && row_last_s;
               // Row-major layout: the next column's top pixel is always base + 1, even across a row change.
               if (col_last_s && row_last_s) begin
                  base_r    <= '0;
                  rd_addr_r <= '0;
                  row_r     <= '0;
               end else begin
                  base_r    <= base_r + ADDR_W'(1);
                  rd_addr_r <= base_r + ADDR_W'(1);
                  if (col_last_s) begin
                     row_r <= row_r + RW'(1);
                  end
               end
               if (col_last_s) begin
                  col_r  <= '0;
                  slot_r <= 2'd0;
               end else begin
                  col_r  <= col_r + CW'(1);
                  slot_r <= (slot_r == 2'd2) ? 2'd0 : slot_r + 2'd1;
               end
            end
            S_DONE: begin
               busy_r <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   // A stalled RD0 masks the strobe in the same cycle so no read is issued.
   assign mem_rd_en   = rd_en_r & ~((state_r == S_RD0) & stall_s);
   assign mem_rd_addr = rd_addr_r;
   assign din1        = din1_r;
   assign din2        = din2_r;
   assign din3        = din3_r;
   assign addr        = addr_r;
   assign enable      = enable_r;
   assign endSign     = end_r;
   assign busy        = busy_r;
   assign done        = done_r;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder: random image contents against a
// window-level reference model with a behavioural 3-slot adder.
module tb_conv_window_feeder;

   localparam int W  = 5;
   localparam int H  = 4;
   localparam int DW = 16;
   localparam int AW = 10;
   localparam int N  = W * (H - 2);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          stall;
   logic          busy;
   logic          done;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data = '0;
   logic [DW-1:0] din1;
   logic [DW-1:0] din2;
   logic [DW-1:0] din3;
   logic [1:0]    addr;
   logic          enable;
   logic          endSign;

   logic [DW-1:0] mem [W*H];
   logic [DW-1:0] e_d1;
   logic [DW-1:0] e_d2;
   logic [DW-1:0] e_d3;
   logic [1:0]    e_addr;
   int            slot_sum [3];
   int            n_vec = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   conv_window_feeder #(
      .WIDTH (W),
      .HEIGHT(H),
      .DATA_W(DW),
      .ADDR_W(AW)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
`ifdef FEEDER_STALL_EN
      .stall      (stall),
`endif
      .start      (start),
      .busy       (busy),
      .done       (done),
      .mem_rd_en  (mem_rd_en),
      .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data),
      .din1       (din1),
      .din2       (din2),
      .din3       (din3),
      .addr       (addr),
      .enable     (enable),
      .endSign    (endSign)
   );

   // Synchronous-read image memory.
   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_rd_data <= (int'(mem_rd_addr) < W * H) ? mem[mem_rd_addr] : 16'hdead;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int win_sum(input int r, input int c);
      int s = 0;
      for (int dr = 0; dr < 3; dr++) begin
         for (int dc = 0; dc < 3; dc++) begin
            s += int'(mem[(r + dr) * W + c - dc]);
         end
      end
      return s;
   endfunction

   // Beat outputs must hold their last loaded values; also feeds the adder model.
   task automatic check_hold();
      chk("din1", 32'(din1), 32'(e_d1));
      chk("din2", 32'(din2), 32'(e_d2));
      chk("din3", 32'(din3), 32'(e_d3));
      chk("addr", 32'(addr), 32'(e_addr));
      if (addr != 2'd3) begin
         slot_sum[addr] = int'(din1) + int'(din2) + int'(din3);
      end
   endtask

   task automatic check_reset();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
      chk("rst_enable", 32'(enable), 32'd0);
      chk("rst_endSign", 32'(endSign), 32'd0);
      e_d1 = '0;
      e_d2 = '0;
      e_d3 = '0;
      e_addr = 2'd0;
      for (int s = 0; s < 3; s++) slot_sum[s] = 0;
      check_hold();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_done", 32'(done), 32'd0);
         chk("idle_enable", 32'(enable), 32'd0);
         chk("idle_endSign", 32'(endSign), 32'd0);
         chk("idle_rd_en", 32'(mem_rd_en), 32'd0);
         check_hold();
         @(posedge clk);
         #1;
      end
   endtask

   // One frame; cycle 0 is the first RD0 cycle. A stall of len cycles starts at RD0 of stall_col.
   task automatic run_frame(input bit hold, input int stall_col, input int len);
      int  s0;
      int  j;
      int  k;
      int  p;
      int  kb;
      bit  stalled;
      bit  first;
      bit  beat;
      bit  exp_rd;
      bit  exp_en;
      s0 = 4 * stall_col;
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      for (int i = 0; i <= 4 * N + len; i++) begin
         stall   = (len > 0) && (i >= s0) && (i < s0 + len);
         stalled = stall;
         if (i == 4 * N + len) start = 1'b0;
         first = !((len > 0) && (i > s0) && (i <= s0 + len));
         if ((len > 0) && (i >= s0 + len)) j = i - len;
         else if (stalled) j = s0;
         else j = i;
         k  = j / 4;
         p  = j % 4;
         kb = k - 1;
         exp_rd = !stalled && (j < 4 * N) && (p != 3);
         beat   = first && (j > 0) && (p == 0);
         exp_en = beat && ((kb % W) >= 2);
         @(negedge clk);
         chk("rd_en", 32'(mem_rd_en), 32'(exp_rd));
         if (exp_rd) chk("rd_addr", 32'(mem_rd_addr), 32'(((k / W) + p) * W + (k % W)));
         if (beat) begin
            e_d1   = mem[kb];
            e_d2   = mem[kb + W];
            e_d3   = mem[kb + 2 * W];
            e_addr = 2'((kb % W) % 3);
         end
         chk("enable", 32'(enable), 32'(exp_en));
         chk("endSign", 32'(endSign), 32'(exp_en && (kb == N - 1)));
         chk("done", 32'(done), 32'(first && (j == 4 * N)));
         chk("busy", 32'(busy), 32'd1);
         check_hold();
         if (exp_en) begin
            chk("win_sum", 32'(slot_sum[0] + slot_sum[1] + slot_sum[2]), 32'(win_sum(kb / W, kb % W)));
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      for (int a = 0; a < W * H; a++) mem[a] = DW'(a);
      repeat (3) @(posedge clk);
      #1;
      check_reset();
      rst = 1'b0;
      idle(2);

      // Ramp image, then a flat image run back-to-back (second start 1 cycle after done).
      run_frame(1'b0, 0, 0);
      idle(2);
      for (int a = 0; a < W * H; a++) mem[a] = DW'(1);
      run_frame(1'b0, 0, 0);
      run_frame(1'b0, 0, 0);
      idle(1);

      // Random images; the second keeps start high for the whole frame.
      for (int f = 0; f < 4; f++) begin
         for (int a = 0; a < W * H; a++) mem[a] = DW'($urandom);
         run_frame(f == 1, 0, 0);
         idle($urandom_range(3, 1));
      end

      // Asynchronous reset in RD2 of column 3, then a clean rerun.
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);
      run_frame(1'b0, 0, 0);
      idle(2);

`ifdef FEEDER_STALL_EN
      run_frame(1'b0, 2, 5);
      idle(2);
      for (int a = 0; a < W * H; a++) mem[a] = DW'($urandom);
      run_frame(1'b0, $urandom_range(N - 1, 1), $urandom_range(6, 1));
      idle(2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Reads a WIDTH x HEIGHT 16-bit image from a synchronous-read pixel memory.
- Drives the 3x3 window adder's write side, column by column: three row values, a column slot index, a window-valid strobe and an end flag.
- Slides the window one column at a time and reuses the adder's slot storage rotationally, so after the first two columns each new window costs one 3-word column fetch.
- Sits between the image memory and the window adder inside the convolution datapath.

Parameters:
WIDTH, 32, image columns (>=3)
HEIGHT, 32, image rows (>=3)
DATA_W, 16, pixel width
ADDR_W, 10, memory address width; WIDTH*HEIGHT <= 2**ADDR_W

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin frame; sampled only in IDLE
busy  out  1  high from accepted start until DONE exits
done  out  1  one-cycle pulse after final beat
mem_rd_en  out  1  memory read strobe
mem_rd_addr  out  ADDR_W  read address = row*WIDTH + col
mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
din1  out  DATA_W  window row 0 value for current column
din2  out  DATA_W  window row 1 value
din3  out  DATA_W  window row 2 value
addr  out  2  adder slot = col mod 3; only values 0..2 ever driven
enable  out  1  window complete; one-cycle pulse
endSign  out  1  high with final enable pulse only

Behaviour:
- Reset (any time, including mid-frame): state IDLE, counters 0. All outputs 0: busy, done, mem_rd_en, mem_rd_addr, din1-3, addr, enable, endSign.
- Counters:
  - row r: 0..HEIGHT-3
  - col c: 0..WIDTH-1
  - hold registers h0, h1 for rows r and r+1
- States: IDLE, RD0, RD1, RD2, LAST, DONE.
- IDLE: start=1 -> r=0, c=0, busy=1, go to RD0. start in any other state is ignored.
- Column sequence, 4 cycles:
  - RD0: mem_rd_en=1, addr r*W+c.
  - RD1: read (r+1)*W+c; capture h0.
  - RD2: read (r+2)*W+c; capture h1.
  - LAST: no read. On exit edge, load din1=h0, din2=h1, din3=mem_rd_data, addr=c mod 3.
  - enable is loaded 1 on that edge iff c>=2.
  - endSign is loaded 1 iff c>=2 and c==WIDTH-1 and r==HEIGHT-3.
- Beat: din/addr are visible in the cycle after LAST. enable/endSign clear on the next edge, so each pulse is exactly 1 cycle with at least 3 low cycles between pulses.
- Output hold: din1-3 and addr hold their last values until the next LAST edge. The adder rewrites the slot every clock, so held values make repeats idempotent. Never drive addr=3.
- Advance after LAST:
  - c<WIDTH-1: c+1, go to RD0.
  - otherwise c=0 and r+1, go to RD0.
  - if r==HEIGHT-3: go to DONE.
- Row change: slot contents from the previous row are overwritten before the next enable, because columns 0 and 1 of the new row refill slots 0 and 1 and column 2 refills slot 2 with enable. No explicit flush.
- DONE: one cycle, done=1; busy drops on the exit edge; go to IDLE.
- Totals:
  - windows = (WIDTH-2)*(HEIGHT-2) enable pulses
  - frame length = 4*WIDTH*(HEIGHT-2) cycles from the RD0 entry to the final beat
- Address arithmetic is unsigned, ADDR_W bits. Parameter violations are flagged at elaboration (error message), not handled at run time.

Optional Feature:
FEEDER_STALL_EN
- Defined: adds input stall (1 bit).
  - Entering RD0 with stall=1 holds the FSM in RD0 with mem_rd_en=0 until stall=0, then issues the read.
  - stall is ignored in the RD1, RD2 and LAST states, so a column fetch is never split.
  - The enable pulse still lasts exactly 1 cycle.
- Undefined: no stall port; timing exactly as above.

Test Plan:
- W=4, H=3, mem[i]=i, start pulse:
  - 2 enable pulses; adder sums 45 then 54
  - addr sequence 0,1,2,0
  - endSign only on the 2nd pulse
  - done 1 cycle after the final beat
- W=3, H=4, mem[i]=1: 2 windows, each sum 9; row change overwrites slots with no extra pulses; total 24 cycles from RD0 to final beat.
- Assert rst mid-column (state RD2) -> all outputs 0 on the same cycle. New start gives the same results as a clean run.
- start held high through the whole frame: one frame only, busy continuous. A start pulse 1 cycle after done begins a second identical frame.
- Idle between beats: din1-3/addr stable for 3 cycles after each beat; enable never high in 2 consecutive cycles.
- FEEDER_STALL_EN defined, stall=1 for 5 cycles at the RD0 of column 2: the enable pulse shifts by 5 cycles, sums unchanged, mem_rd_en low throughout the stall.
